// File: rtl/dvp_pkg.sv
// Shared DVP definitions: FSM states, pattern codes and the colour-bar table.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } state_t;

    localparam logic [1:0] PAT_COUNT = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_SOLID = 2'd2;
    localparam logic [1:0] PAT_FRAME = 2'd3;

    localparam int CNT_W = 16;

    // RGB565 colour bars: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational test-pattern byte generator; high byte of each pixel first.
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 8,
    parameter int XW       = 3
) (
    input  logic [1:0]    pat_sel,
    input  logic [XW-1:0] x,
    input  logic          phase,
    input  logic [7:0]    frame_cnt,
    input  logic [15:0]   solid,
    output logic [7:0]    data
);

    logic [XW:0]  byte_idx;
    logic [2:0]   bar_idx;
    logic [15:0]  bar_rgb;

    // Select the byte for the current pixel/phase; bar index uses the full-width product
    always_comb begin
        byte_idx = {x, phase};
        bar_idx  = 3'((32'(x) * 32'd8) / 32'(H_ACTIVE));
        bar_rgb  = bar_color(bar_idx);
        data     = 8'h00;
        case (pat_sel)
            PAT_COUNT: data = 8'(byte_idx);
            PAT_BARS:  data = phase ? bar_rgb[7:0] : bar_rgb[15:8];
            PAT_SOLID: data = phase ? solid[7:0] : solid[15:8];
            default:   data = frame_cnt;
        endcase
    end

endmodule

// File: rtl/dvp_sensor_tx.sv
// DVP camera-sensor emulator: pclk = clk/2, frame timing FSM, test patterns.
// All timing state advances on the clk edge that drives pclk low, so every
// output decoded from it is stable at the pclk rising edge.
module dvp_sensor_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE  = 8,
    parameter int V_ACTIVE  = 4,
    parameter int H_BLANK   = 4,
    parameter int VSYNC_LEN = 6,
    parameter int V_BACK    = 5,
    parameter int V_FRONT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pat_sel,
    input  logic [15:0] solid_rgb,
    output logic        pclk,
    output logic        href,
    output logic        vsync,
    output logic [7:0]  data,
    output logic        strobe,
    output logic [15:0] frame_cnt,
    output logic        frame_done
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] line, line_n;
    logic [15:0]      frame_cnt_q, frame_cnt_n;
    logic [15:0]      solid_q, solid_n;
    logic [1:0]       pat_q, pat_n;
    logic             pclk_q, pclk_n;
    logic             done_q, done_n;
    logic [7:0]       pix;

    // State, counters and frame-latched pattern settings
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            line        <= '0;
            frame_cnt_q <= '0;
            solid_q     <= '0;
            pat_q       <= PAT_COUNT;
            pclk_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            line        <= line_n;
            frame_cnt_q <= frame_cnt_n;
            solid_q     <= solid_n;
            pat_q       <= pat_n;
            pclk_q      <= pclk_n;
            done_q      <= done_n;
        end
    end

    // Next-state logic; pclk_q=1 means this edge ends a tick
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        line_n      = line;
        frame_cnt_n = frame_cnt_q;
        solid_n     = solid_q;
        pat_n       = pat_q;
        done_n      = 1'b0;
        pclk_n      = (state != ST_IDLE) ? ~pclk_q : 1'b0;
        if (state == ST_IDLE) begin
            if (en) begin
                state_n = ST_VSYNC;
                cnt_n   = '0;
                pat_n   = pat_sel;
                solid_n = solid_rgb;
            end
        end else if (pclk_q) begin
            cnt_n = cnt + 1'b1;
            case (state)
                ST_VSYNC: if (cnt == CNT_W'(VSYNC_LEN - 1)) begin
                    state_n = ST_VBACK;
                    cnt_n   = '0;
                end
                ST_VBACK: if (cnt == CNT_W'(V_BACK - 1)) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = '0;
                    line_n  = '0;
                end
                ST_ACTIVE: if (cnt == CNT_W'(2 * H_ACTIVE - 1)) begin
                    cnt_n   = '0;
                    state_n = (line == CNT_W'(V_ACTIVE - 1)) ? ST_VFRONT : ST_HBLANK;
                end
                ST_HBLANK: if (cnt == CNT_W'(H_BLANK - 1)) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = '0;
                    line_n  = line + 1'b1;
                end
                ST_VFRONT: if (cnt == CNT_W'(V_FRONT - 1)) begin
                    cnt_n       = '0;
                    frame_cnt_n = frame_cnt_q + 1'b1;
                    done_n      = 1'b1;
                    if (en) begin
                        state_n = ST_VSYNC;
                        pat_n   = pat_sel;
                        solid_n = solid_rgb;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    dvp_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW)
    ) u_pat (
        .pat_sel   (pat_q),
        .x         (cnt[XW:1]),
        .phase     (cnt[0]),
        .frame_cnt (frame_cnt_q[7:0]),
        .solid     (solid_q),
        .data      (pix)
    );

    assign pclk       = pclk_q;
    assign href       = (state == ST_ACTIVE);
    assign vsync      = (state == ST_VSYNC);
    assign strobe     = vsync;
    assign data       = href ? pix : 8'h00;
    assign frame_cnt  = frame_cnt_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_dvp_sensor_tx.sv
// Directed bench for dvp_sensor_tx with a byte scoreboard.
module tb_dvp_sensor_tx;

    localparam int H_ACTIVE  = 8;
    localparam int V_ACTIVE  = 4;
    localparam int H_BLANK   = 4;
    localparam int VSYNC_LEN = 6;
    localparam int V_BACK    = 5;
    localparam int V_FRONT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pat_sel = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic        pclk, href, vsync, strobe, frame_done;
    logic [7:0]  data;
    logic [15:0] frame_cnt;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    dvp_sensor_tx #(
        .H_ACTIVE (H_ACTIVE), .V_ACTIVE (V_ACTIVE), .H_BLANK (H_BLANK),
        .VSYNC_LEN (VSYNC_LEN), .V_BACK (V_BACK), .V_FRONT (V_FRONT)
    ) dut (
        .clk (clk), .rst (rst), .en (en), .pat_sel (pat_sel),
        .solid_rgb (solid_rgb), .pclk (pclk), .href (href), .vsync (vsync),
        .data (data), .strobe (strobe), .frame_cnt (frame_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bytes for one whole frame
    task automatic push_frame(input int pat, input logic [15:0] solid, input logic [7:0] fb);
        logic [15:0] rgb;
        for (int l = 0; l < V_ACTIVE; l++) begin
            for (int b = 0; b < 2 * H_ACTIVE; b++) begin
                case (pat)
                    0: exp_q.push_back(8'(b));
                    1: begin
                        rgb = bars[((b / 2) * 8) / H_ACTIVE];
                        exp_q.push_back((b % 2) ? rgb[7:0] : rgb[15:8]);
                    end
                    2: exp_q.push_back((b % 2) ? solid[7:0] : solid[15:8]);
                    default: exp_q.push_back(fb);
                endcase
            end
        end
    endtask

    // Scoreboard: sample each pclk-high half, away from clk edges
    always @(negedge clk) begin
        logic [7:0] e;
        if (frame_done) done_cnt++;
        if (rst && pclk) begin
            if (href) begin
                if (exp_q.size() == 0) begin
                    check("pix_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("pix", {24'h0, data}, {24'h0, e});
                end
            end else begin
                check("blank_data", {24'h0, data}, 32'h0);
            end
            check("strobe_eq_vsync", {31'h0, strobe}, {31'h0, vsync});
        end
    end

    // Advance to the next pclk-high sample point
    task automatic tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (pclk) return;
        end
        check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_len(input bit use_href, input logic val, output int n);
        n = 0;
        while (((use_href ? href : vsync) === val) && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_vsync();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (vsync && pclk) return;
        end
        check("vsync_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (frame_done) begin
                #1;
                return;
            end
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int base;
        // Reset state
        #1;
        check("rst_pclk", {31'h0, pclk}, 32'h0);
        check("rst_href", {31'h0, href}, 32'h0);
        check("rst_vsync", {31'h0, vsync}, 32'h0);
        check("rst_data", {24'h0, data}, 32'h0);
        check("rst_fcnt", {16'h0, frame_cnt}, 32'h0);
        check("rst_done", {31'h0, frame_done}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_pclk", {31'h0, pclk}, 32'h0);

        // Frame A: pattern 0, full timing measurement
        pat_sel = 2'd0;
        push_frame(0, 16'h0, 8'h0);
        en = 1'b1;
        wait_vsync();
        run_len(0, 1'b1, n); check("vsync_len", 32'(n), 32'(VSYNC_LEN));
        run_len(1, 1'b0, n); check("vback_len", 32'(n), 32'(V_BACK));
        for (int l = 0; l < V_ACTIVE; l++) begin
            run_len(1, 1'b1, n); check("line_len", 32'(n), 32'(2 * H_ACTIVE));
            if (l == 0) begin
                // mid-frame change only affects the next frame
                pat_sel = 2'd1;
                push_frame(1, 16'h0, 8'h0);
            end
            if (l < V_ACTIVE - 1) begin
                run_len(1, 1'b0, n); check("hblank_len", 32'(n), 32'(H_BLANK));
            end
        end
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (frame_done) break;
            if (pclk) n++;
        end
        check("vfront_len", 32'(n), 32'(V_FRONT));
        #1;
        check("fcnt_a", {16'h0, frame_cnt}, 32'd1);
        check("done_a", 32'(done_cnt), 32'd1);

        // Frame B: colour bars, en dropped during line 2
        wait_vsync();
        run_len(0, 1'b1, n);
        run_len(1, 1'b0, n);
        run_len(1, 1'b1, n);
        run_len(1, 1'b0, n);
        en = 1'b0;
        wait_done();
        check("fcnt_b", {16'h0, frame_cnt}, 32'd2);
        check("drain_b", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("idle_pclk_b", {30'h0, pclk, vsync}, 32'h0);
        end
        check("done_once_b", 32'(done_cnt), 32'd2);

        // Frame C: solid colour latched at VSYNC entry
        pat_sel = 2'd2;
        solid_rgb = 16'h1234;
        push_frame(2, 16'h1234, 8'h0);
        en = 1'b1;
        wait_vsync();
        en = 1'b0;
        solid_rgb = 16'hABCD;
        pat_sel = 2'd0;
        wait_done();
        check("fcnt_c", {16'h0, frame_cnt}, 32'd3);
        check("drain_c", 32'(exp_q.size()), 32'd0);

        // Reset asserted during ACTIVE
        push_frame(0, 16'h0, 8'h0);
        en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (href && pclk) break;
        end
        check("href_seen", {31'h0, href}, 32'h1);
        base = done_cnt;
        #1 rst = 1'b0;
        #1;
        check("arst_pclk", {31'h0, pclk}, 32'h0);
        check("arst_href", {31'h0, href}, 32'h0);
        check("arst_vsync", {31'h0, vsync}, 32'h0);
        check("arst_strobe", {31'h0, strobe}, 32'h0);
        check("arst_data", {24'h0, data}, 32'h0);
        check("arst_fcnt", {16'h0, frame_cnt}, 32'h0);
        exp_q.delete();
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("arst_no_done", 32'(done_cnt), 32'(base));
        rst = 1'b1;

        // Frame counter wrap, then pattern 3 shows the frame number
        force dut.frame_cnt_q = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        release dut.frame_cnt_q;
        #1;
        check("preset_fcnt", {16'h0, frame_cnt}, 32'hFFFF);
        pat_sel = 2'd3;
        push_frame(3, 16'h0, 8'hFF);
        en = 1'b1;
        wait_vsync();
        en = 1'b0;
        wait_done();
        check("wrap_fcnt", {16'h0, frame_cnt}, 32'h0);
        check("drain_wrap", 32'(exp_q.size()), 32'd0);
        push_frame(3, 16'h0, 8'h00);
        en = 1'b1;
        wait_vsync();
        en = 1'b0;
        wait_done();
        check("post_wrap_fcnt", {16'h0, frame_cnt}, 32'h1);
        check("drain_post", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dvp_sensor_tx.md
DVP_SENSOR_TX -- requirements
Module: dvp_sensor_tx

Interface
REQ-001 Parameter H_ACTIVE, default 8, pixels per active line.
REQ-002 Parameter V_ACTIVE, default 4, active lines per frame.
REQ-003 Parameter H_BLANK, default 4, pclk periods href low between lines.
REQ-004 Parameter VSYNC_LEN, default 6, pclk periods vsync high.
REQ-005 Parameter V_BACK, default 5, pclk periods from vsync fall to first href rise.
REQ-006 Parameter V_FRONT, default 3, pclk periods from last href fall to frame end.
REQ-007 clk  input  1  system clock; the single clock domain.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 en  input  1  frame generation enable.
REQ-010 pat_sel  input  2  pattern: 0 byte counter, 1 colour bars, 2 solid, 3 frame number.
REQ-011 solid_rgb  input  16  RGB565 value for pattern 2.
REQ-012 pclk  output  1  pixel clock to the capture side, clk/2.
REQ-013 href  output  1  line-valid, high while data bytes are valid.
REQ-014 vsync  output  1  frame-sync pulse, active high.
REQ-015 data  output  8  pixel byte, RGB565, high byte first.
REQ-016 strobe  output  1  flash strobe, equal to vsync.
REQ-017 frame_cnt  output  16  completed-frame count.
REQ-018 frame_done  output  1  one-clk pulse at end of each frame.

Function
REQ-019 pclk SHALL toggle every clk cycle while running; one "tick" is one pclk period, i.e. 2 clk cycles.
REQ-020 href, vsync, data and strobe SHALL change only on the clk edge that drives pclk low, so they are stable at pclk rise.
REQ-021 The FSM SHALL have states IDLE, VSYNC, VBACK, ACTIVE, HBLANK and VFRONT.
REQ-022 IDLE->VSYNC SHALL occur when en=1 at a tick boundary; pclk SHALL be held low in IDLE.
REQ-023 VSYNC SHALL last VSYNC_LEN ticks with vsync=1, then VBACK for V_BACK ticks, then ACTIVE.
REQ-024 ACTIVE SHALL last 2*H_ACTIVE ticks with href=1, then HBLANK for H_BLANK ticks, then ACTIVE again.
REQ-025 After line V_ACTIVE, ACTIVE SHALL go directly to VFRONT (no trailing HBLANK); VFRONT lasts V_FRONT ticks.
REQ-026 At VFRONT end: frame_cnt increments (wraps at 0xFFFF to 0) and frame_done pulses for 1 clk.
REQ-027 Next state after VFRONT is VSYNC if en=1 in that clk, else IDLE.
REQ-028 en deassert mid-frame SHALL NOT truncate the current frame.
REQ-029 While href=0, data SHALL be 0x00.
REQ-030 Pixel x (0..H_ACTIVE-1) SHALL be sent as byte 2x = RGB565[15:8] and byte 2x+1 = RGB565[7:0].
REQ-031 Pattern 0: data = byte index within the line, modulo 256.
REQ-032 Pattern 1: colour = BAR[(x*8)/H_ACTIVE], where BAR = FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000; the product is computed at full width, with no truncation before the divide.
REQ-033 Pattern 2: colour = solid_rgb, sampled once at VSYNC entry and held for the frame.
REQ-034 Pattern 3: every byte = frame_cnt[7:0].
REQ-035 pat_sel SHALL be sampled at VSYNC entry only; mid-frame changes take effect next frame.

Reset
REQ-036 rst=0 SHALL asynchronously force IDLE with pclk=0, href=0, vsync=0, strobe=0, data=0x00, frame_cnt=0 and frame_done=0.
REQ-037 Reset mid-frame SHALL abort the frame with no frame_done; after release the first frame starts from VSYNC.

Structure
REQ-038 State encoding, the BAR colour table and pattern codes SHALL live in shared package dvp_pkg, reused by the capture block.
REQ-039 Pattern generation SHALL be sub-module dvp_pattern_gen, combinational from (pat_sel, x, byte phase, frame_cnt, solid).

Verification
REQ-040 Reset, then en=1 with defaults -> vsync high 6 ticks, href rises 5 ticks later, 4 lines of 16 bytes with 4-tick gaps, frame_done after 3 ticks; frame_cnt=1.
REQ-041 Pattern 0 -> each line's bytes are 0x00..0x0F; 0x00 during blanking.
REQ-042 Pattern 1, H_ACTIVE=8 -> byte pairs FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00.
REQ-043 en dropped during line 2 -> frame completes, frame_done pulses once, then IDLE with pclk low.
REQ-044 rst asserted during ACTIVE -> all outputs 0 immediately; no frame_done; frame_cnt=0.
REQ-045 frame_cnt preset near wrap (force 0xFFFF) -> next frame_done gives 0x0000; pattern 3 then sends 0x00 bytes.
